// File: rtl/sys_bridge_if.sv
// sys_bridge_if
// Bus bundle between the CPU/device side and the sys_bridge.
//   CPU side    : PrAddr, PrWD, PrWE, PrRE (to bridge), PrRD, bus_err (from bridge)
//   Device side : DEV_Addr, DEV_WD, DEV0_WE, DEV1_WE (from bridge),
//                 DEV0_RD, DEV1_RD, intrp0, intrp1 (to bridge)
//   Interrupts  : HWInt[7:2] (from bridge)
// Modports: slave = bridge view, master = CPU/device environment view.
interface sys_bridge_if;
  logic [31:0] PrAddr;
  logic [31:0] PrWD;
  logic        PrWE;
  logic        PrRE;
  logic [31:0] PrRD;
  logic        bus_err;
  logic [31:0] DEV_Addr;
  logic [31:0] DEV_WD;
  logic        DEV0_WE;
  logic        DEV1_WE;
  logic [31:0] DEV0_RD;
  logic [31:0] DEV1_RD;
  logic        intrp0;
  logic        intrp1;
  logic [7:2]  HWInt;

  modport slave (
    input  PrAddr, PrWD, PrWE, PrRE, DEV0_RD, DEV1_RD, intrp0, intrp1,
    output PrRD, bus_err, DEV_Addr, DEV_WD, DEV0_WE, DEV1_WE, HWInt
  );

  modport master (
    output PrAddr, PrWD, PrWE, PrRE, DEV0_RD, DEV1_RD, intrp0, intrp1,
    input  PrRD, bus_err, DEV_Addr, DEV_WD, DEV0_WE, DEV1_WE, HWInt
  );
endinterface

// File: rtl/sys_bridge.sv
// sys_bridge
// Address-decoding bridge between a CPU and two timer devices, with a small
// interrupt pending/mask register pair.
// Ports:
//   clk   : system clock, all state on the rising edge
//   reset : asynchronous active-low reset
//   bus   : sys_bridge_if.slave (CPU strobes/data, device selects/data,
//           interrupt requests and HWInt outputs)
// Configuration macro: BRIDGE_EDGE_IRQ_EN
//   defined   -> IRQ_PEND latches rising edges of intrp0/1, write-1-to-clear
//   undefined -> IRQ_PEND is a registered copy of the interrupt levels
module sys_bridge #(
  parameter logic [31:0] DEV0_BASE = 32'h0000_7F00,
  parameter logic [31:0] DEV1_BASE = 32'h0000_7F10,
  parameter logic [31:0] IRQ_BASE  = 32'h0000_7F20
) (
  input logic          clk,
  input logic          reset,
  sys_bridge_if.slave  bus
);

  logic        aligned;
  logic        hit0;
  logic        hit1;
  logic        hit_pend;
  logic        hit_mask;
  logic        any_hit;
  logic [31:0] rd_sel;
  logic [31:0] pr_rd;
  logic        err_q;
  logic [1:0]  irq_pend;
  logic [1:0]  irq_mask;
  logic [1:0]  intrp;

  assign intrp = {bus.intrp1, bus.intrp0};

  // Each device window is three words; anything unaligned never hits.
  always_comb begin
    aligned  = (bus.PrAddr[1:0] == 2'b00);
    hit0     = aligned && ((bus.PrAddr == DEV0_BASE) ||
                           (bus.PrAddr == DEV0_BASE + 32'd4) ||
                           (bus.PrAddr == DEV0_BASE + 32'd8));
    hit1     = aligned && ((bus.PrAddr == DEV1_BASE) ||
                           (bus.PrAddr == DEV1_BASE + 32'd4) ||
                           (bus.PrAddr == DEV1_BASE + 32'd8));
    hit_pend = aligned && (bus.PrAddr == IRQ_BASE);
    hit_mask = aligned && (bus.PrAddr == IRQ_BASE + 32'd4);
    any_hit  = hit0 || hit1 || hit_pend || hit_mask;
  end

  assign bus.DEV_Addr = bus.PrAddr;
  assign bus.DEV_WD   = bus.PrWD;
  assign bus.DEV0_WE  = bus.PrWE && hit0;
  assign bus.DEV1_WE  = bus.PrWE && hit1;
  assign bus.PrRD     = pr_rd;
  assign bus.bus_err  = err_q;
  assign bus.HWInt    = {4'b0000, irq_pend & irq_mask};

  // Read mux uses current register values, so a simultaneous write to the
  // same register returns the pre-write contents.
  always_comb begin
    rd_sel = 32'h0;
    if (hit0)          rd_sel = bus.DEV0_RD;
    else if (hit1)     rd_sel = bus.DEV1_RD;
    else if (hit_pend) rd_sel = {30'h0, irq_pend};
    else if (hit_mask) rd_sel = {30'h0, irq_mask};
  end

  // Read data register and one-cycle error pulse for any bad access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pr_rd <= 32'h0;
      err_q <= 1'b0;
    end else begin
      if (bus.PrRE) pr_rd <= rd_sel;
      err_q <= (bus.PrWE || bus.PrRE) && !any_hit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_mask <= 2'b11;
    end else if (bus.PrWE && hit_mask) begin
      irq_mask <= bus.PrWD[1:0];
    end
  end

`ifdef BRIDGE_EDGE_IRQ_EN
  logic [1:0] intrp_prev;
  logic       armed;
  logic [1:0] rise;
  logic [1:0] clr;

  // armed stays low for the first post-reset cycle so a line already high
  // at release is taken as history, not as a fresh edge.
  always_comb begin
    rise = intrp & ~intrp_prev & {2{armed}};
    clr  = (bus.PrWE && hit_pend) ? bus.PrWD[1:0] : 2'b00;
  end

  // Set has priority over a coincident write-1-to-clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      intrp_prev <= 2'b00;
      armed      <= 1'b0;
      irq_pend   <= 2'b00;
    end else begin
      intrp_prev <= intrp;
      armed      <= 1'b1;
      irq_pend   <= (irq_pend & ~clr) | rise;
    end
  end
`else
  // Level mode: pending simply tracks the request lines one cycle late.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_pend <= 2'b00;
    end else begin
      irq_pend <= intrp;
    end
  end
`endif

endmodule

// File: doc/sys_bridge.md
SYS_BRIDGE -- requirements
Module: sys_bridge

Interface
REQ-001 Parameter DEV0_BASE, 32'h0000_7F00, word-aligned base of timer device 0 window (3 words).
REQ-002 Parameter DEV1_BASE, 32'h0000_7F10, word-aligned base of timer device 1 window (3 words).
REQ-003 Parameter IRQ_BASE, 32'h0000_7F20, base of bridge registers: +0 IRQ_PEND, +4 IRQ_MASK.
REQ-004 clk  input  1  single system clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 PrAddr  input  32  CPU byte address.
REQ-007 PrWD  input  32  CPU write data.
REQ-008 PrWE  input  1  CPU write strobe, one cycle per write.
REQ-009 PrRE  input  1  CPU read strobe, one cycle per read.
REQ-010 PrRD  output  32  registered read data.
REQ-011 bus_err  output  1  one-cycle pulse flagging a bad access.
REQ-012 DEV_Addr, DEV_WD  output  32 each  address/data broadcast to devices.
REQ-013 DEV0_WE, DEV1_WE  output  1 each  per-device write enables.
REQ-014 DEV0_RD, DEV1_RD  input  32 each  combinational device read data.
REQ-015 intrp0, intrp1  input  1 each  device interrupt requests.
REQ-016 HWInt  output  6  CPU hardware interrupt lines [7:2].

Function
REQ-017 DEV_Addr=PrAddr, DEV_WD=PrWD, combinational.
REQ-018 Hit = PrAddr[1:0]==0 and PrAddr in {base, base+4, base+8} for DEV0/DEV1, or {IRQ_BASE, IRQ_BASE+4} for bridge.
REQ-019 DEVn_WE = PrWE & hitn, same cycle, combinational; never both high.
REQ-020 PrRD updates at the edge where PrRE=1 with selected data (DEVn_RD, IRQ_PEND zero-extended, IRQ_MASK zero-extended); holds otherwise; 1-cycle read latency.
REQ-021 Read of non-hit address loads PrRD=0.
REQ-022 PrRE and PrWE same cycle, same address: PrRD gets pre-write value.
REQ-023 PrWE or PrRE to non-hit or misaligned address: write suppressed, bus_err=1 for exactly the next cycle.
REQ-024 IRQ_MASK[1:0] read/write; write loads PrWD[1:0]; bits [31:2] read 0.
REQ-025 HWInt = {4'b0, IRQ_PEND[1:0] & IRQ_MASK[1:0]}, combinational from registers.
REQ-026 IRQ_PEND behaviour per Configuration; bits [31:2] read 0.

Reset
REQ-027 reset low asynchronously forces: PrRD=0, bus_err=0, IRQ_PEND=0, IRQ_MASK=2'b11, interrupt history flops=0; HWInt=0.
REQ-028 Access in progress at reset assertion is discarded; no bus_err after release.
REQ-029 Interrupt already high at reset release is not treated as a rising edge in its first post-reset cycle.

Configuration
REQ-030 Macro BRIDGE_EDGE_IRQ_EN defined: IRQ_PEND[i] sets on rising edge of intrp_i (intrp_i=1, prior-cycle sample=0); write to IRQ_BASE clears bits where PrWD[i]=1 (W1C); set and clear same cycle -> set wins.
REQ-031 Macro undefined: IRQ_PEND[i] <= intrp_i every cycle (registered level, 1-cycle delay); writes to IRQ_BASE ignored, no bus_err.

Verification
REQ-032 PrWE=1, PrAddr=32'h7F04, PrWD=32'h55 -> DEV0_WE=1, DEV1_WE=0 same cycle, DEV_WD=32'h55.
REQ-033 PrRE=1, PrAddr=32'h7F18, DEV1_RD=32'hABCD -> PrRD=32'hABCD next cycle, held after PrRE drops.
REQ-034 PrWE=1, PrAddr=32'h7F0C (or 32'h7F02) -> no DEVn_WE, bus_err high exactly one cycle; PrRE to 32'h8000 -> PrRD=0.
REQ-035 EDGE_EN: intrp1 rises and stays high -> HWInt=6'b000010 next cycle; write 32'h2 to 32'h7F20 -> HWInt=0, stays 0 while intrp1 held high.
REQ-036 EDGE_EN: clear write coincident with new intrp0 rising edge -> IRQ_PEND[0]=1 retained; IRQ_MASK write 32'h0 -> HWInt=0 with IRQ_PEND unchanged.
REQ-037 reset pulsed low mid-read -> PrRD=0, IRQ_MASK=2'b11, IRQ_PEND=0 immediately, no clock edge needed.
